uns_nxm_seq_mult: RTL and testbench

//  Parametrised unsigned N x M sequential multiplier; successor to the fixed 3x3 ALU+counter unit.

---
 rtl/mult_pkg.sv | 26 ++
 rtl/uns_mult_dp.sv | 107 ++++++++++
 rtl/uns_nxm_seq_mult.sv | 130 +++++++++++++
 tb/tb_uns_nxm_seq_mult.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
//   Shared definitions for the unsigned N x M sequential multiplier.
//   - mult_state_t : controller state encoding (READY/INIT/COMPUTE/RES)
//   - MULT_A_WIDTH / MULT_B_WIDTH : default operand widths
//   - mult_count_width() : width of the cycle counter for a given B width
// ---------------------------------------------------------------------------
package mult_pkg;

  typedef enum logic [1:0] {
    S_READY,
    S_INIT,
    S_COMPUTE,
    S_RES
  } mult_state_t;

  localparam int MULT_A_WIDTH = 8;
  localparam int MULT_B_WIDTH = 8;

  // The counter is loaded with B_WIDTH and counts down to 1, so it needs to
  // represent the value B_WIDTH itself.
  function automatic int mult_count_width(input int b_width);
    return $clog2(b_width + 1);
  endfunction

endpackage

// File: rtl/uns_mult_dp.sv
// ---------------------------------------------------------------------------
// uns_mult_dp
//   Shift-and-add datapath of the sequential multiplier. Holds the shifted
//   multiplicand (a_reg), the shifted multiplier (b_reg), the accumulator,
//   the remaining-cycle counter and the visible product register.
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   a, b           : operands, loaded when load=1
//   load           : initialise all working registers from a/b
//   shift          : perform one partial-product step
//   capture        : copy this step's accumulator result into f_reg
//   b_lsb          : current multiplier LSB (partial product enable)
//   b_next_zero    : multiplier becomes zero after this step
//   count_is_1     : this is the last step of the full-length schedule
//   f_reg          : product register, holds until the next capture
// ---------------------------------------------------------------------------
module uns_mult_dp
  import mult_pkg::*;
#(
  parameter int A_WIDTH = MULT_A_WIDTH,
  parameter int B_WIDTH = MULT_B_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic                       load,
  input  logic                       shift,
  input  logic                       capture,
  output logic                       b_lsb,
  output logic                       b_next_zero,
  output logic                       count_is_1,
  output logic [A_WIDTH+B_WIDTH-1:0] f_reg
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int C_WIDTH = mult_count_width(B_WIDTH);

  logic [P_WIDTH-1:0] a_reg_q, a_reg_d;
  logic [B_WIDTH-1:0] b_reg_q, b_reg_d;
  logic [P_WIDTH-1:0] acc_q,   acc_d;
  logic [C_WIDTH-1:0] count_q, count_d;
  logic [P_WIDTH-1:0] f_reg_q, f_reg_d;
  logic [P_WIDTH-1:0] acc_sum;

  // Accumulator value after the current step's conditional add. Used both
  // for the step itself and for the product capture on the exit edge, so the
  // final partial product is never lost.
  always_comb begin
    acc_sum = acc_q + (b_reg_q[0] ? a_reg_q : '0);
  end

  // Next-state logic for the working registers. Load wins over shift; the
  // controller never asserts both together.
  always_comb begin
    a_reg_d = a_reg_q;
    b_reg_d = b_reg_q;
    acc_d   = acc_q;
    count_d = count_q;
    f_reg_d = f_reg_q;

    if (load) begin
      a_reg_d = {{B_WIDTH{1'b0}}, a};
      b_reg_d = b;
      acc_d   = '0;
      count_d = C_WIDTH'(B_WIDTH);
    end else if (shift) begin
      acc_d   = acc_sum;
      a_reg_d = a_reg_q << 1;
      b_reg_d = b_reg_q >> 1;
      // Guard against wrap; the controller leaves COMPUTE at count 1 anyway.
      if (count_q != '0) begin
        count_d = count_q - C_WIDTH'(1);
      end
    end

    if (capture) begin
      f_reg_d = acc_sum;
    end
  end

  // Register bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg_q <= '0;
      b_reg_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      f_reg_q <= '0;
    end else begin
      a_reg_q <= a_reg_d;
      b_reg_q <= b_reg_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      f_reg_q <= f_reg_d;
    end
  end

  // Status flags for the controller.
  always_comb begin
    b_lsb       = b_reg_q[0];
    b_next_zero = ((b_reg_q >> 1) == '0);
    count_is_1  = (count_q == C_WIDTH'(1));
    f_reg       = f_reg_q;
  end

endmodule

// File: rtl/uns_nxm_seq_mult.sv
// ---------------------------------------------------------------------------
// uns_nxm_seq_mult
//   Parametrised unsigned A_WIDTH x B_WIDTH sequential multiplier. One
//   partial product per clock, optional early exit once the remaining
//   multiplier bits are zero, back-to-back operation when GO is held in RES.
// Ports
//   SYS_CLOCK     : system clock, rising edge
//   FSM_ARESET_N  : asynchronous active-low reset
//   GO            : start request, honoured only in READY and RES
//   A, B          : operands, captured while in INIT
//   READY/INIT/COMPUTE/RES : one-hot state indicators
//   F_VALID       : one-cycle pulse coincident with RES
//   F_REG         : product, held until the next RES
// ---------------------------------------------------------------------------
module uns_nxm_seq_mult
  import mult_pkg::*;
#(
  parameter int A_WIDTH    = MULT_A_WIDTH,
  parameter int B_WIDTH    = MULT_B_WIDTH,
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                       SYS_CLOCK,
  input  logic                       FSM_ARESET_N,
  input  logic                       GO,
  input  logic [A_WIDTH-1:0]         A,
  input  logic [B_WIDTH-1:0]         B,
  output logic                       READY,
  output logic                       INIT,
  output logic                       COMPUTE,
  output logic                       RES,
  output logic                       F_VALID,
  output logic [A_WIDTH+B_WIDTH-1:0] F_REG
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;

  mult_state_t state_q, state_d;

  logic load;
  logic shift;
  logic capture;
  logic b_lsb;
  logic b_next_zero;
  logic count_is_1;
  logic compute_done;

  logic [P_WIDTH-1:0] f_reg;

  uns_mult_dp #(
    .A_WIDTH (A_WIDTH),
    .B_WIDTH (B_WIDTH)
  ) u_dp (
    .clk         (SYS_CLOCK),
    .rst_n       (FSM_ARESET_N),
    .a           (A),
    .b           (B),
    .load        (load),
    .shift       (shift),
    .capture     (capture),
    .b_lsb       (b_lsb),
    .b_next_zero (b_next_zero),
    .count_is_1  (count_is_1),
    .f_reg       (f_reg)
  );

  // The LSB is consumed inside the datapath's adder; the controller only
  // needs the exit conditions.
  logic unused_b_lsb;
  assign unused_b_lsb = b_lsb;

  // COMPUTE ends after the last scheduled step, or earlier when no set
  // multiplier bits remain above the one being processed now.
  always_comb begin
    compute_done = count_is_1 || (EARLY_TERM && b_next_zero);
  end

  // Next-state and datapath control. Capture fires on the same edge that
  // leaves COMPUTE so F_REG is already valid during RES.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    shift   = 1'b0;
    capture = 1'b0;

    case (state_q)
      S_READY: begin
        if (GO) begin
          state_d = S_INIT;
        end
      end
      S_INIT: begin
        load    = 1'b1;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        shift = 1'b1;
        if (compute_done) begin
          capture = 1'b1;
          state_d = S_RES;
        end
      end
      S_RES: begin
        state_d = GO ? S_INIT : S_READY;
      end
      default: begin
        state_d = S_READY;
      end
    endcase
  end

  // State register.
  always_ff @(posedge SYS_CLOCK or negedge FSM_ARESET_N) begin
    if (!FSM_ARESET_N) begin
      state_q <= S_READY;
    end else begin
      state_q <= state_d;
    end
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    READY   = (state_q == S_READY);
    INIT    = (state_q == S_INIT);
    COMPUTE = (state_q == S_COMPUTE);
    RES     = (state_q == S_RES);
    F_VALID = (state_q == S_RES);
    F_REG   = f_reg;
  end

endmodule

// File: tb/tb_uns_nxm_seq_mult.sv
module tb_uns_nxm_seq_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] go_in;
  logic [7:0] a_in [3];
  logic [7:0] b_in [3];

  logic [2:0]  rdy, ini, cmp, res, vld;
  logic [15:0] f0, f1;
  logic [5:0]  f3;
  logic [15:0] f_out [3];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // DUT 0: 8x8 with early exit, DUT 1: 8x8 full length, DUT 2: 3x3 early exit
  uns_nxm_seq_mult #(.A_WIDTH(8), .B_WIDTH(8), .EARLY_TERM(1'b1)) dut_e (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go_in[0]), .A(a_in[0]), .B(b_in[0]),
    .READY(rdy[0]), .INIT(ini[0]), .COMPUTE(cmp[0]), .RES(res[0]), .F_VALID(vld[0]), .F_REG(f0));

  uns_nxm_seq_mult #(.A_WIDTH(8), .B_WIDTH(8), .EARLY_TERM(1'b0)) dut_n (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go_in[1]), .A(a_in[1]), .B(b_in[1]),
    .READY(rdy[1]), .INIT(ini[1]), .COMPUTE(cmp[1]), .RES(res[1]), .F_VALID(vld[1]), .F_REG(f1));

  uns_nxm_seq_mult #(.A_WIDTH(3), .B_WIDTH(3), .EARLY_TERM(1'b1)) dut_s (
    .SYS_CLOCK(clk), .FSM_ARESET_N(rst_n), .GO(go_in[2]), .A(a_in[2][2:0]), .B(b_in[2][2:0]),
    .READY(rdy[2]), .INIT(ini[2]), .COMPUTE(cmp[2]), .RES(res[2]), .F_VALID(vld[2]), .F_REG(f3));

  always_comb begin
    f_out[0] = f0;
    f_out[1] = f1;
    f_out[2] = {10'b0, f3};
  end

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: phase 0..3 = idle/load/compute/result, compute length
  // from the operand's MSB position, product by plain multiplication.
  int     aw [3] = '{8, 8, 3};
  int     bw [3] = '{8, 8, 3};
  int     early [3] = '{1, 0, 1};
  int     ph [3];
  int     rem [3];
  longint op_a [3], op_b [3], exp_f [3];

  function automatic int msbIndex(input longint v);
    int m = 0;
    for (int k = 0; k < 32; k++) if (((v >> k) & 1) != 0) m = k + 1;
    return m;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        ph[i] = 0; rem[i] = 0; exp_f[i] = 0; op_a[i] = 0; op_b[i] = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        case (ph[i])
          0: if (go_in[i]) ph[i] = 1;
          1: begin
            op_a[i] = longint'(a_in[i]) & ((64'd1 << aw[i]) - 1);
            op_b[i] = longint'(b_in[i]) & ((64'd1 << bw[i]) - 1);
            if (early[i] != 0) rem[i] = (msbIndex(op_b[i]) < 1) ? 1 : msbIndex(op_b[i]);
            else rem[i] = bw[i];
            ph[i] = 2;
          end
          2: begin
            rem[i]--;
            if (rem[i] == 0) begin
              exp_f[i] = op_a[i] * op_b[i];
              ph[i] = 3;
            end
          end
          default: ph[i] = go_in[i] ? 1 : 0;
        endcase
      end
    end
  end

  // Per-cycle comparison of all three DUTs against the model.
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        checkOutput($sformatf("status%0d", i),
                    longint'({rdy[i], ini[i], cmp[i], res[i], vld[i]}),
                    longint'({ph[i] == 0, ph[i] == 1, ph[i] == 2, ph[i] == 3, ph[i] == 3}));
        checkOutput($sformatf("f_reg%0d", i), longint'(f_out[i]), exp_f[i]);
      end
    end
  end

  // Wait for RES on one DUT, counting cycles and COMPUTE cycles; bounded.
  task automatic waitRes(input int idx, input int limit, output int lat, output int ncmp);
    lat = 0;
    ncmp = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (cmp[idx]) ncmp++;
      if (res[idx]) return;
      if (lat >= limit) begin
        checks++;
        errors++;
        $display("[TB] FAIL timeout%0d: got no RES within %0d cycles, expected RES", idx, limit);
        return;
      end
    end
  endtask

  // One GO pulse with operands held; returns latency (GO edge to RES) and
  // COMPUTE cycle count.
  task automatic applyStimulus(input int idx, input logic [7:0] a, input logic [7:0] b,
                               output int lat, output int ncmp);
    int l2, n2;
    @(negedge clk);
    go_in[idx] = 1'b1;
    a_in[idx] = a;
    b_in[idx] = b;
    @(negedge clk);
    go_in[idx] = 1'b0;
    waitRes(idx, 40, l2, n2);
    lat = l2 + 1;
    ncmp = n2;
  endtask

  int lat, ncmp;

  initial begin
    rst_n = 1'b0;
    go_in = '0;
    for (int i = 0; i < 3; i++) begin
      a_in[i] = '0;
      b_in[i] = '0;
    end
    started = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_ready", longint'(rdy[0]), 1);
    checkOutput("reset_status", longint'({ini[0], cmp[0], res[0], vld[0]}), 0);
    checkOutput("reset_f", longint'(f_out[0]), 0);
    rst_n = 1'b1;

    $display("[TB] test 1: 3 x 5 early exit");
    applyStimulus(0, 8'd3, 8'd5, lat, ncmp);
    checkOutput("t1_ncmp", ncmp, 3);
    checkOutput("t1_f", longint'(f_out[0]), 15);
    checkOutput("t1_valid", longint'(vld[0]), 1);
    @(negedge clk);
    checkOutput("t1_valid_drop", longint'(vld[0]), 0);
    checkOutput("t1_back_ready", longint'(rdy[0]), 1);

    $display("[TB] test 2: 255 x 255");
    applyStimulus(0, 8'd255, 8'd255, lat, ncmp);
    checkOutput("t2_ncmp", ncmp, 8);
    checkOutput("t2_latency", lat, 10);
    checkOutput("t2_f", longint'(f_out[0]), 65025);

    $display("[TB] test 3: B = 0");
    applyStimulus(0, 8'd200, 8'd0, lat, ncmp);
    checkOutput("t3e_ncmp", ncmp, 1);
    checkOutput("t3e_f", longint'(f_out[0]), 0);
    applyStimulus(1, 8'd3, 8'd5, lat, ncmp);
    checkOutput("t3n_pre_ncmp", ncmp, 8);
    checkOutput("t3n_pre_f", longint'(f_out[1]), 15);
    applyStimulus(1, 8'd200, 8'd0, lat, ncmp);
    checkOutput("t3n_ncmp", ncmp, 8);
    checkOutput("t3n_f", longint'(f_out[1]), 0);

    $display("[TB] test 4: back-to-back");
    @(negedge clk);
    go_in[0] = 1'b1;
    a_in[0] = 8'd7;
    b_in[0] = 8'd9;
    @(negedge clk);
    @(negedge clk);
    a_in[0] = 8'd12;
    b_in[0] = 8'd12;
    waitRes(0, 40, lat, ncmp);
    checkOutput("t4_f1", longint'(f_out[0]), 63);
    @(negedge clk);
    checkOutput("t4_direct_init", longint'({rdy[0], ini[0]}), 1);
    go_in[0] = 1'b0;
    waitRes(0, 40, lat, ncmp);
    checkOutput("t4_f2", longint'(f_out[0]), 144);

    $display("[TB] test 5: reset during COMPUTE");
    @(negedge clk);
    go_in[0] = 1'b1;
    a_in[0] = 8'd255;
    b_in[0] = 8'd255;
    @(negedge clk);
    go_in[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_in_compute", longint'(cmp[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t5_ready", longint'(rdy[0]), 1);
    checkOutput("t5_status", longint'({ini[0], cmp[0], res[0], vld[0]}), 0);
    checkOutput("t5_f", longint'(f_out[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 8'd6, 8'd6, lat, ncmp);
    checkOutput("t5_f_after", longint'(f_out[0]), 36);
    checkOutput("t5_ncmp", ncmp, 3);

    $display("[TB] test 6: 3x3 exhaustive");
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        applyStimulus(2, 8'(a), 8'(b), lat, ncmp);
        checkOutput($sformatf("t6_%0dx%0d", a, b), longint'(f_out[2]), a * b);
      end
    end

    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
